// File: rtl/game_scheduler.sv
// game_scheduler: frame-paced game step generator with keyboard-driven IDLE/PLAY/PAUSE/OVER control.
module game_scheduler #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int MIN_FRAMES      = 2,
  parameter int STEPS_PER_LEVEL = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vs,
  input  logic [9:0] keyboard,
  input  logic       collide,
  output logic       step,
  output logic       stop,
  output logic [1:0] state,
  output logic [2:0] level
);
  localparam int FW = $clog2(FRAMES_PER_STEP + MIN_FRAMES + 1);
  localparam int SW = ($clog2(STEPS_PER_LEVEL) > 5) ? $clog2(STEPS_PER_LEVEL) : 5;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;
  state_t        state_q, state_d;
  logic [2:0]    vs_q;
  logic [9:0]    kb_q;
  logic [FW-1:0] frm_q, frm_d, period;
  logic [SW-1:0] stp_q, stp_d;
  logic [2:0]    level_q, level_d;
  logic          frame_tick, key_evt, key_ok, k_enter, k_space, k_esc, play, leave, last_step;
  // vs_q[1:0] is the synchronizer, vs_q[2] the edge-detect history
  assign frame_tick = vs_q[1] & ~vs_q[2];
  assign key_evt    = (keyboard != kb_q) & ~keyboard[9];
  assign key_ok     = key_evt & ~keyboard[8];
  assign k_enter    = key_ok & (keyboard[7:0] == 8'h5A);
  assign k_space    = key_ok & (keyboard[7:0] == 8'h29);
  assign k_esc      = key_ok & (keyboard[7:0] == 8'h76);
  assign play       = state_q == PLAY;
  assign leave      = k_esc | collide | k_space;
  assign period     = (FRAMES_PER_STEP - int'(level_q) > MIN_FRAMES) ?
                      FW'(FRAMES_PER_STEP - int'(level_q)) : FW'(MIN_FRAMES);
  assign step       = play & ~leave & frame_tick & (frm_q == period - FW'(1));
  assign last_step  = stp_q == SW'(STEPS_PER_LEVEL - 1);
  assign stop       = ~play;
  assign state      = state_q;
  assign level      = level_q;
  always_comb begin
    state_d = state_q;
    if (k_esc) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = k_enter ? PLAY : IDLE;
        PLAY:    state_d = collide ? OVER : (k_space ? PAUSE : PLAY);
        PAUSE:   state_d = k_space ? PLAY : PAUSE;
        OVER:    state_d = k_enter ? IDLE : OVER;
        default: state_d = IDLE;
      endcase
    end
  end
  // Frame ticks are only consumed while staying in PLAY, so nothing is buffered across a pause
  always_comb begin
    frm_d   = frm_q;
    stp_d   = stp_q;
    level_d = level_q;
    if (state_q == IDLE && state_d == PLAY) begin
      frm_d   = '0;
      stp_d   = '0;
      level_d = '0;
    end else if (play && !leave && frame_tick) begin
      frm_d = step ? '0 : frm_q + FW'(1);
      if (step) begin
        stp_d   = last_step ? '0 : stp_q + SW'(1);
        level_d = (last_step && level_q != 3'd7) ? level_q + 3'd1 : level_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vs_q    <= '0;
      kb_q    <= '0;
      frm_q   <= '0;
      stp_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= {vs_q[1:0], vs};
      kb_q    <= keyboard;
      frm_q   <= frm_d;
      stp_q   <= stp_d;
      level_q <= level_d;
    end
  end
endmodule

// File: tb/tb_game_scheduler.sv
// tb_game_scheduler: table-driven key/FSM vectors plus directed frame/step/level/reset sequences.
module tb_game_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vs = 1'b0;
  logic [9:0] keyboard = 10'h000;
  logic       collide = 1'b0;
  logic       step, stop;
  logic [1:0] state;
  logic [2:0] level;
  int checks = 0;
  int errors = 0;
  int step_seen = 0;
  int width_err = 0;
  logic prev_step = 1'b0;

  game_scheduler dut (
    .clk(clk), .reset(reset), .vs(vs), .keyboard(keyboard), .collide(collide),
    .step(step), .stop(stop), .state(state), .level(level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step) step_seen++;
    if (step && prev_step) width_err++;
    prev_step = step;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [9:0] kb;
    logic       col;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vs = 1'b1;
    repeat (4) cyc();
    vs = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    int base;
    tbl[0]  = '{10'h000, 1'b0, 2'd0};
    tbl[1]  = '{10'h029, 1'b0, 2'd0};
    tbl[2]  = '{10'h15A, 1'b0, 2'd0};
    tbl[3]  = '{10'h25A, 1'b0, 2'd0};
    tbl[4]  = '{10'h05A, 1'b0, 2'd1};
    tbl[5]  = '{10'h05A, 1'b0, 2'd1};
    tbl[6]  = '{10'h229, 1'b0, 2'd1};
    tbl[7]  = '{10'h029, 1'b0, 2'd2};
    tbl[8]  = '{10'h029, 1'b1, 2'd2};
    tbl[9]  = '{10'h229, 1'b0, 2'd2};
    tbl[10] = '{10'h029, 1'b0, 2'd1};
    tbl[11] = '{10'h05A, 1'b0, 2'd1};
    tbl[12] = '{10'h05A, 1'b1, 2'd3};
    tbl[13] = '{10'h029, 1'b0, 2'd3};
    tbl[14] = '{10'h05A, 1'b0, 2'd0};
    tbl[15] = '{10'h076, 1'b0, 2'd0};
    tbl[16] = '{10'h05A, 1'b0, 2'd1};
    tbl[17] = '{10'h029, 1'b1, 2'd3};
    tbl[18] = '{10'h076, 1'b0, 2'd0};
    tbl[19] = '{10'h05A, 1'b0, 2'd1};
    tbl[20] = '{10'h076, 1'b1, 2'd0};

    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_stop", int'(stop), 1);
    chk("rst_step", int'(step), 0);
    chk("rst_level", int'(level), 0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 21; i++) begin
      keyboard = tbl[i].kb;
      collide  = tbl[i].col;
      cyc();
      chk($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].st));
      chk($sformatf("vec%0d_stop", i), int'(stop), (tbl[i].st != 2'd1) ? 1 : 0);
      chk($sformatf("vec%0d_step", i), int'(step), 0);
    end
    collide = 1'b0;

    keyboard = 10'h05A;
    cyc();
    chk("play_state", int'(state), 1);
    chk("play_stop", int'(stop), 0);
    base = step_seen;
    for (int f = 1; f <= 16; f++) begin
      frame();
      chk($sformatf("frame%0d_steps", f), step_seen - base, f / 8);
    end

    run_frames(3);
    keyboard = 10'h029;
    cyc();
    chk("pause_state", int'(state), 2);
    chk("pause_stop", int'(stop), 1);
    base = step_seen;
    run_frames(10);
    chk("pause_no_step", step_seen - base, 0);
    keyboard = 10'h129;
    cyc();
    chk("ext_space_ignored", int'(state), 2);
    keyboard = 10'h029;
    cyc();
    chk("resume_state", int'(state), 1);
    run_frames(4);
    chk("resume_held_count", step_seen - base, 0);
    frame();
    chk("resume_step", step_seen - base, 1);

    run_frames(7);
    base = step_seen;
    vs = 1'b1;
    cyc();
    cyc();
    collide = 1'b1;
    @(negedge clk);
    chk("collide_step_gated", int'(step), 0);
    @(posedge clk);
    #1;
    collide = 1'b0;
    chk("collide_over", int'(state), 3);
    chk("collide_no_step", step_seen - base, 0);
    vs = 1'b0;
    repeat (4) cyc();
    keyboard = 10'h05A;
    cyc();
    chk("over_enter_idle", int'(state), 0);

    keyboard = 10'h000;
    cyc();
    keyboard = 10'h05A;
    cyc();
    chk("lvl_entry_state", int'(state), 1);
    chk("lvl_entry_level", int'(level), 0);
    base = step_seen;
    run_frames(256);
    chk("lvl1_level", int'(level), 1);
    chk("lvl1_steps", step_seen - base, 32);
    base = step_seen;
    run_frames(6);
    chk("p7_early", step_seen - base, 0);
    frame();
    chk("p7_step", step_seen - base, 1);
    run_frames(31 * 7);
    chk("lvl2_level", int'(level), 2);
    for (int l = 2; l <= 6; l++) begin
      run_frames(32 * ((8 - l > 2) ? 8 - l : 2));
      chk($sformatf("lvl%0d_level", l + 1), int'(level), l + 1);
    end
    base = step_seen;
    frame();
    chk("p2_early", step_seen - base, 0);
    frame();
    chk("p2_step", step_seen - base, 1);
    run_frames(62);
    chk("lvl_saturate", int'(level), 7);
    base = step_seen;
    run_frames(2);
    chk("sat_period", step_seen - base, 1);
    chk("sat_level", int'(level), 7);

    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_stop", int'(stop), 1);
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_step", int'(step), 0);
    keyboard = 10'h000;
    @(negedge clk);
    #1;
    reset = 1'b1;
    cyc();
    chk("post_rst_idle", int'(state), 0);
    keyboard = 10'h05A;
    cyc();
    chk("post_rst_play", int'(state), 1);
    chk("post_rst_level", int'(level), 0);

    chk("step_width", width_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
